// File: rtl/sram22_march_bist.sv
// rtl/sram22_march_bist.sv - March C- BIST initiator for one sram22 single-port macro
//
// Purpose: runs M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1);
// M4 down(r1,w0); M5 up(r0) over every address, one op per cycle.
// It stops at the first read mismatch and reports it; otherwise it reports a pass.
//
// Ports:
//   clk, rst                         clock shared with the SRAM, async active-high reset
//   start                            begin a run; sampled only in IDLE or DONE
//   busy / done / fail               run status; fail is valid while done=1
//   fail_addr / fail_exp / fail_got  address, expected word and read word of the first mismatch
//   sram_we / sram_wmask / sram_addr / sram_din   registered SRAM command
//   sram_dout                        SRAM read data, valid the cycle after the read edge

module sram22_march_bist #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int WMASK_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0]  fail_exp,
    output logic [DATA_WIDTH-1:0]  fail_got,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX  = '1;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WMASK_WIDTH-1:0] MASK_ALL  = '1;
    localparam logic [WMASK_WIDTH-1:0] MASK_NONE = '0;
    localparam logic [DATA_WIDTH-1:0]  DATA_ZERO = '0;

    state_t                 state_q, state_d;
    logic [2:0]             elem_q, elem_d;       // current March element 0..5
    logic                   phase_q, phase_d;     // 0 = first op of element, 1 = second op
    logic                   op_rd_q, op_rd_d;     // op currently presented to the SRAM is a read
    logic [DATA_WIDTH-1:0]  op_exp_q, op_exp_d;   // expected word of that read
    logic                   rd_pend_q, rd_pend_d; // read sampled last edge; data on sram_dout now
    logic [DATA_WIDTH-1:0]  rd_exp_q, rd_exp_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0]  fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0]  fail_got_q, fail_got_d;
    logic                   sram_we_q, sram_we_d;
    logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
    logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;

    // Position of the op that follows the one currently presented.
    logic [2:0]             nxt_elem;
    logic                   nxt_phase;
    logic [ADDR_WIDTH-1:0]  nxt_addr;
    logic                   last_op;
    logic                   nxt_rd;
    logic [DATA_WIDTH-1:0]  nxt_pat;
    logic                   mismatch;

    // M0 is write-only, M5 read-only; two-op elements read first, then write.
    function automatic logic op_is_read(input logic [2:0] e, input logic p);
        if (e == 3'd0) begin
            return 1'b0;
        end else if (e == 3'd5) begin
            return 1'b1;
        end
        return ~p;
    endfunction

    // Reads expect ones in M2/M4; writes store ones in M1/M3.
    function automatic logic op_pattern_bit(input logic [2:0] e, input logic rd);
        if (rd) begin
            return (e == 3'd2) || (e == 3'd4);
        end
        return (e == 3'd1) || (e == 3'd3);
    endfunction

    always_comb begin
        nxt_elem  = elem_q;
        nxt_phase = phase_q;
        nxt_addr  = sram_addr_q;
        last_op   = 1'b0;
        case (elem_q)
            3'd0: begin
                if (sram_addr_q == ADDR_MAX) begin
                    nxt_elem = 3'd1;
                    nxt_addr = ADDR_ZERO;
                end else begin
                    nxt_addr = sram_addr_q + ADDR_ONE;
                end
            end
            3'd1, 3'd2: begin
                if (!phase_q) begin
                    nxt_phase = 1'b1;
                end else begin
                    nxt_phase = 1'b0;
                    if (sram_addr_q == ADDR_MAX) begin
                        nxt_elem = elem_q + 3'd1;
                        // M1 hands over to ascending M2, M2 to descending M3
                        nxt_addr = (elem_q == 3'd1) ? ADDR_ZERO : ADDR_MAX;
                    end else begin
                        nxt_addr = sram_addr_q + ADDR_ONE;
                    end
                end
            end
            3'd3, 3'd4: begin
                if (!phase_q) begin
                    nxt_phase = 1'b1;
                end else begin
                    nxt_phase = 1'b0;
                    if (sram_addr_q == ADDR_ZERO) begin
                        nxt_elem = elem_q + 3'd1;
                        // M3 hands over to descending M4, M4 to ascending M5
                        nxt_addr = (elem_q == 3'd3) ? ADDR_MAX : ADDR_ZERO;
                    end else begin
                        nxt_addr = sram_addr_q - ADDR_ONE;
                    end
                end
            end
            3'd5: begin
                if (sram_addr_q == ADDR_MAX) begin
                    last_op = 1'b1;
                end else begin
                    nxt_addr = sram_addr_q + ADDR_ONE;
                end
            end
            default: begin
                last_op = 1'b1;
            end
        endcase
        nxt_rd  = op_is_read(nxt_elem, nxt_phase);
        nxt_pat = {DATA_WIDTH{op_pattern_bit(nxt_elem, nxt_rd)}};
    end

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        phase_d      = phase_q;
        op_rd_d      = op_rd_q;
        op_exp_d     = op_exp_q;
        rd_pend_d    = rd_pend_q;
        rd_exp_d     = rd_exp_q;
        rd_addr_d    = rd_addr_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_got_d   = fail_got_q;
        sram_we_d    = sram_we_q;
        sram_wmask_d = sram_wmask_q;
        sram_addr_d  = sram_addr_q;
        sram_din_d   = sram_din_q;
        mismatch     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                op_rd_d   = 1'b0;
                rd_pend_d = 1'b0;
                sram_we_d = 1'b0;
                if (start) begin
                    // op0 (w0 @ 0) is issued at the accepting edge
                    state_d      = S_RUN;
                    fail_d       = 1'b0;
                    elem_d       = 3'd0;
                    phase_d      = 1'b0;
                    sram_we_d    = 1'b1;
                    sram_wmask_d = MASK_ALL;
                    sram_addr_d  = ADDR_ZERO;
                    sram_din_d   = DATA_ZERO;
                end
            end
            S_RUN, S_DRAIN: begin
                // Read presented this cycle is sampled at this edge; its data
                // is compared one edge later.
                rd_pend_d = op_rd_q;
                rd_exp_d  = op_exp_q;
                rd_addr_d = sram_addr_q;
                mismatch  = rd_pend_q && (sram_dout != rd_exp_q);

                if (mismatch) begin
                    state_d     = S_DONE;
                    fail_d      = 1'b1;
                    fail_addr_d = rd_addr_q;
                    fail_exp_d  = rd_exp_q;
                    fail_got_d  = sram_dout;
                    sram_we_d   = 1'b0;
                    op_rd_d     = 1'b0;
                    rd_pend_d   = 1'b0;
                end else if (state_q == S_DRAIN) begin
                    state_d   = S_DONE;
                    rd_pend_d = 1'b0;
                end else if (last_op) begin
                    state_d   = S_DRAIN;
                    sram_we_d = 1'b0;
                    op_rd_d   = 1'b0;
                end else begin
                    elem_d       = nxt_elem;
                    phase_d      = nxt_phase;
                    sram_addr_d  = nxt_addr;
                    sram_we_d    = ~nxt_rd;
                    sram_wmask_d = nxt_rd ? MASK_NONE : MASK_ALL;
                    sram_din_d   = nxt_rd ? DATA_ZERO : nxt_pat;
                    op_rd_d      = nxt_rd;
                    op_exp_d     = nxt_pat;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            elem_q       <= 3'd0;
            phase_q      <= 1'b0;
            op_rd_q      <= 1'b0;
            op_exp_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_exp_q     <= '0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
            sram_we_q    <= 1'b0;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            phase_q      <= phase_d;
            op_rd_q      <= op_rd_d;
            op_exp_q     <= op_exp_d;
            rd_pend_q    <= rd_pend_d;
            rd_exp_q     <= rd_exp_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_got_q   <= fail_got_d;
            sram_we_q    <= sram_we_d;
            sram_wmask_q <= sram_wmask_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_exp   = fail_exp_q;
    assign fail_got   = fail_got_q;
    assign sram_we    = sram_we_q;
    assign sram_wmask = sram_wmask_q;
    assign sram_addr  = sram_addr_q;
    assign sram_din   = sram_din_q;

endmodule
